hilo_mdu: RTL
=============

HILO_MDU -- requirements
Module: hilo_mdu

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 start  in  1  E-stage instruction uses MDU this cycle; qualifies op.
REQ-004 op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
REQ-005 A  in  32  rs operand (forwarded).
REQ-006 B  in  32  rt operand (forwarded).
REQ-007 req  in  1  exception/interrupt request from M stage; suppresses E-stage side effects.
REQ-008 busy  out  1  registered; high while a mult/div is in flight.
REQ-009 HILO_out  out  32  combinational; HI when op=MFHI, else LO.

Function
REQ-010 Accepted start: start=1 & req=0 & busy=0; any other start SHALL be ignored with no state change.
REQ-011 Accepted MULT/MULTU SHALL compute the 64-bit signed/unsigned product of A, B at the accept edge into pending {hi,lo}; busy=1 for exactly 5 cycles after that edge.
REQ-012 Accepted DIV/DIVU SHALL compute quotient to pending lo and remainder to pending hi; busy=1 for exactly 10 cycles.
REQ-013 Signed divide SHALL truncate toward zero; remainder takes dividend sign; 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
REQ-014 Divide by zero SHALL still run 10 busy cycles and leave HI/LO unchanged.
REQ-015 Internal counter SHALL load latency at accept, decrement each cycle; at the edge it reaches 0, HI/LO take pending values and busy falls on that same edge.
REQ-016 HI/LO SHALL hold old values throughout busy; MFHI/MFLO during busy return old values (stall unit prevents this in practice).
REQ-017 Accepted MTHI/MTLO SHALL write A into HI/LO at that edge; no busy, single cycle.
REQ-018 MFHI/MFLO SHALL have no state effect; HILO_out is valid the same cycle.
REQ-019 req=1 SHALL NOT cancel an in-flight operation; it blocks only a new accept.
REQ-020 Stall logic outside SHALL use (start | busy); this block exports busy only.

Reset
REQ-021 On reset: HI=0, LO=0, pending=0, counter=0, busy=0; HILO_out=0 as a consequence.
REQ-022 Reset during busy SHALL discard the pending result; first accept after release behaves as from power-up.

Structure
REQ-023 Shared package SHALL hold the op encodings and MULT_CYCLES=5, DIV_CYCLES=10.
REQ-024 Single module, no sub-module; arithmetic via built-in operators, one 4-bit counter, 64-bit pending register.

Verification
REQ-025 MULT A=0xFFFFFFFF B=2 -> busy cycles 1-5, then HI=0xFFFFFFFF LO=0xFFFFFFFE.
REQ-026 MULTU A=0xFFFFFFFF B=2 -> after 5 cycles HI=0x00000001 LO=0xFFFFFFFE.
REQ-027 DIV A=0xFFFFFFF9 (-7) B=2 -> after 10 cycles LO=0xFFFFFFFD HI=0xFFFFFFFF; DIVU 7/0 -> HI/LO unchanged, busy 10 cycles.
REQ-028 MTHI A=0x12345678 then MFHI -> HILO_out=0x12345678 next cycle; MTLO with req=1 -> LO unchanged.
REQ-029 DIV accepted, reset asserted at busy cycle 4 -> busy=0, HI=LO=0 immediately; no late write after reset release.
REQ-030 start while busy (MULT 3*3 issued at busy cycle 2 of prior MULT 2*2) -> ignored; final LO=4, busy width 5 only.

Source files
------------

// File: rtl/hilo_mdu_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: op encodings,
// operation latencies and the signed/unsigned divide helper.
package hilo_mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MFHI  = 3'd6,
        OP_MFLO  = 3'd7
    } op_e;

    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;

    // Returns {remainder, quotient}. Works on magnitudes so that
    // 0x80000000 / -1 never reaches a signed-overflow divide.
    function automatic logic [63:0] divide(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic        is_signed);
        logic        neg_a;
        logic        neg_b;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] quo;
        logic [31:0] rem;
        neg_a = is_signed & a[31];
        neg_b = is_signed & b[31];
        mag_a = neg_a ? -a : a;
        mag_b = neg_b ? -b : b;
        quo   = mag_a / mag_b;
        rem   = mag_a % mag_b;
        if (neg_a ^ neg_b) quo = -quo;
        if (neg_a)         rem = -rem;
        return {rem, quo};
    endfunction

endpackage

// File: rtl/hilo_mdu.sv
// HI/LO multiply-divide unit: fixed-latency mult/div into a pending register
// that is committed to HI/LO when the countdown expires.
module hilo_mdu
    import hilo_mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        req,
    output logic        busy,
    output logic [31:0] HILO_out
);

    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic [63:0] pend_reg;
    logic [3:0]  cnt_reg;
    logic        busy_reg;

    op_e         op_q;
    logic        accept;
    logic [63:0] mul_res;
    logic [63:0] div_res;

    assign op_q   = op_e'(op);
    assign accept = start & ~req & ~busy_reg;

    always_comb begin
        mul_res = 64'd0;
        div_res = 64'd0;
        if (op_q == OP_MULT)
            mul_res = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        else
            mul_res = {32'd0, A} * {32'd0, B};
        // A zero divisor commits the current HI/LO back, i.e. leaves them unchanged.
        if (B == 32'd0)
            div_res = {hi_reg, lo_reg};
        else
            div_res = divide(A, B, op_q == OP_DIV);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_reg   <= 32'd0;
            lo_reg   <= 32'd0;
            pend_reg <= 64'd0;
            cnt_reg  <= 4'd0;
            busy_reg <= 1'b0;
        end else if (busy_reg) begin
            cnt_reg <= cnt_reg - 4'd1;
            if (cnt_reg == 4'd1) begin
                busy_reg <= 1'b0;
                hi_reg   <= pend_reg[63:32];
                lo_reg   <= pend_reg[31:0];
            end
        end else if (accept) begin
            case (op_q)
                OP_MULT, OP_MULTU: begin
                    pend_reg <= mul_res;
                    cnt_reg  <= MULT_CYCLES;
                    busy_reg <= 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    pend_reg <= div_res;
                    cnt_reg  <= DIV_CYCLES;
                    busy_reg <= 1'b1;
                end
                OP_MTHI: hi_reg <= A;
                OP_MTLO: lo_reg <= A;
                default: ;
            endcase
        end
    end

    assign busy     = busy_reg;
    assign HILO_out = (op_q == OP_MFHI) ? hi_reg : lo_reg;

endmodule
